// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered, handshaked RV32I/RV64I immediate generator with 2-entry skid buffer
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst_code,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic [2:0]      fmt_out,
  output logic [XLEN-1:0] target_out,
  output logic            illegal_out
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] FMT_ZIMM  = 3'd7;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_IMM_32  = 7'b0011011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  if (DEPTH != 2) begin : g_bad_depth
    $error("imm_gen_pipe: DEPTH must be 2");
  end
  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm, dec_tgt;
  logic [2:0]      dec_fmt;
  logic            dec_ill;

  assign opcode   = inst_code[6:0];
  assign funct3   = inst_code[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i = {{(XLEN-12){inst_code[31]}}, inst_code[31:20]};
  assign imm_s = {{(XLEN-12){inst_code[31]}}, inst_code[31:25], inst_code[11:7]};
  assign imm_b = {{(XLEN-13){inst_code[31]}}, inst_code[31], inst_code[7],
                  inst_code[30:25], inst_code[11:8], 1'b0};
  // Shifting out the top 12 sign copies leaves bit 31 replicated above at XLEN=64.
  assign imm_u = {{(XLEN-20){inst_code[31]}}, inst_code[31:12]} << 12;
  assign imm_j = {{(XLEN-21){inst_code[31]}}, inst_code[31], inst_code[19:12],
                  inst_code[20], inst_code[30:21], 1'b0};

  // Opcode-driven selection of immediate, format and illegal flag.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    dec_ill = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_imm = imm_i;
        dec_fmt = FMT_I;
      end
      OP_IMM: begin
        if (is_shift) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) begin
            dec_imm = XLEN'(inst_code[25:20]);
          end else begin
            dec_imm = XLEN'(inst_code[24:20]);
            dec_ill = inst_code[25];
          end
        end else begin
          dec_imm = imm_i;
          dec_fmt = FMT_I;
        end
      end
      OP_IMM_32: begin
        if (XLEN == 64) begin
          if (is_shift) begin
            dec_imm = XLEN'(inst_code[24:20]);
            dec_fmt = FMT_SHAMT;
          end else begin
            dec_imm = imm_i;
            dec_fmt = FMT_I;
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      OP_STORE: begin
        dec_imm = imm_s;
        dec_fmt = FMT_S;
      end
      OP_BRANCH: begin
        dec_imm = imm_b;
        dec_fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm = imm_u;
        dec_fmt = FMT_U;
      end
      OP_JAL: begin
        dec_imm = imm_j;
        dec_fmt = FMT_J;
      end
      OP_SYSTEM: begin
        if (funct3[2]) begin
          dec_imm = XLEN'(inst_code[19:15]);
          dec_fmt = FMT_ZIMM;
        end else if (funct3 != 3'b000) begin
          dec_imm = imm_i;
          dec_fmt = FMT_I;
        end
      end
      default: ;
    endcase
  end

  // PC-relative target only for branches, JAL and AUIPC (not LUI, not JALR).
  assign dec_tgt = (dec_fmt == FMT_B || dec_fmt == FMT_J || opcode == OP_AUIPC)
                   ? pc_in + dec_imm : '0;

  logic [XLEN-1:0] imm_q [2];
  logic [XLEN-1:0] tgt_q [2];
  logic [2:0]      fmt_q [2];
  logic            ill_q [2];
  logic [1:0]      count;
  logic            wr_ptr, rd_ptr;
  logic            ready_en;
  logic            push, pop;

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  // Buffer storage; contents are masked by out_valid so they need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr] <= dec_imm;
      tgt_q[wr_ptr] <= dec_tgt;
      fmt_q[wr_ptr] <= dec_fmt;
      ill_q[wr_ptr] <= dec_ill;
    end
  end

  // Occupancy and pointer control; flush overrides push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (flush) begin
        count  <= 2'd0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  assign imm_out     = out_valid ? imm_q[rd_ptr] : '0;
  assign target_out  = out_valid ? tgt_q[rd_ptr] : '0;
  assign fmt_out     = out_valid ? fmt_q[rd_ptr] : 3'd0;
  assign illegal_out = out_valid ? ill_q[rd_ptr] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - table-driven bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst_code = '0;
  logic [31:0] pc_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] imm_out;
  logic [2:0]  fmt_out;
  logic [31:0] target_out;
  logic        illegal_out;

  logic        in_valid64 = 1'b0;
  logic        in_ready64;
  logic [31:0] inst64 = '0;
  logic [63:0] pc64 = '0;
  logic        out_valid64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [63:0] tgt64;
  logic        ill64;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .inst_code(inst_code), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm_out(imm_out), .fmt_out(fmt_out),
    .target_out(target_out), .illegal_out(illegal_out)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .inst_code(inst64), .pc_in(pc64),
    .out_valid(out_valid64), .out_ready(1'b1),
    .imm_out(imm64), .fmt_out(fmt64),
    .target_out(tgt64), .illegal_out(ill64)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec64_t;

  vec_t   vecs[15];
  vec64_t v64s[3];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input int i);
    chk($sformatf("v%0d_valid", i), 64'(out_valid), 64'd1);
    chk($sformatf("v%0d_imm", i), 64'(imm_out), 64'(vecs[i].imm));
    chk($sformatf("v%0d_fmt", i), 64'(fmt_out), 64'(vecs[i].fmt));
    chk($sformatf("v%0d_tgt", i), 64'(target_out), 64'(vecs[i].tgt));
    chk($sformatf("v%0d_ill", i), 64'(illegal_out), 64'(vecs[i].ill));
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 32'h0,    32'hFFFFFFFF, 3'd1, 32'h0,    1'b0}; // addi -1
    vecs[1]  = '{32'h4030D093, 32'h0,    32'h00000003, 3'd6, 32'h0,    1'b0}; // srai 3
    vecs[2]  = '{32'h02009093, 32'h0,    32'h00000000, 3'd6, 32'h0,    1'b1}; // slli bit25
    vecs[3]  = '{32'hFE000CE3, 32'h100,  32'hFFFFFFF8, 3'd3, 32'hF8,   1'b0}; // beq -8
    vecs[4]  = '{32'h123452B7, 32'h40,   32'h12345000, 3'd4, 32'h0,    1'b0}; // lui
    vecs[5]  = '{32'h00001017, 32'h200,  32'h00001000, 3'd4, 32'h1200, 1'b0}; // auipc
    vecs[6]  = '{32'h008000EF, 32'h1000, 32'h00000008, 3'd5, 32'h1008, 1'b0}; // jal +8
    vecs[7]  = '{32'hFE112E23, 32'h0,    32'hFFFFFFFC, 3'd2, 32'h0,    1'b0}; // sw -4
    vecs[8]  = '{32'h00412083, 32'h0,    32'h00000004, 3'd1, 32'h0,    1'b0}; // lw 4
    vecs[9]  = '{32'h3402D073, 32'h0,    32'h00000005, 3'd7, 32'h0,    1'b0}; // csrrwi zimm 5
    vecs[10] = '{32'h00000073, 32'h0,    32'h00000000, 3'd0, 32'h0,    1'b0}; // ecall
    vecs[11] = '{32'h34011073, 32'h0,    32'h00000340, 3'd1, 32'h0,    1'b0}; // csrrw
    vecs[12] = '{32'h0010009B, 32'h0,    32'h00000000, 3'd0, 32'h0,    1'b1}; // addiw on RV32
    vecs[13] = '{32'h00000033, 32'h0,    32'h00000000, 3'd0, 32'h0,    1'b0}; // add (no imm)
    vecs[14] = '{32'hFFC080E7, 32'h500,  32'hFFFFFFFC, 3'd1, 32'h0,    1'b0}; // jalr, no target

    v64s[0] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui sign-extended
    v64s[1] = '{32'h02009093, 64'h0000000000000020, 3'd6, 1'b0}; // slli 32 legal
    v64s[2] = '{32'h0010009B, 64'h0000000000000001, 3'd1, 1'b0}; // addiw

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_imm", 64'(imm_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // Back-to-back vectors at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_valid  = 1'b1;
      inst_code = vecs[i].inst;
      pc_in     = vecs[i].pc;
      @(negedge clk);
      chk_vec(i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_imm_zero", 64'(imm_out), 64'd0);

    // XLEN=64 instance
    for (int i = 0; i < 3; i++) begin
      in_valid64 = 1'b1;
      inst64     = v64s[i].inst;
      pc64       = 64'h1000;
      @(negedge clk);
      chk($sformatf("x64_%0d_valid", i), 64'(out_valid64), 64'd1);
      chk($sformatf("x64_%0d_imm", i), imm64, v64s[i].imm);
      chk($sformatf("x64_%0d_fmt", i), 64'(fmt64), 64'(v64s[i].fmt));
      chk($sformatf("x64_%0d_ill", i), 64'(ill64), 64'(v64s[i].ill));
      chk($sformatf("x64_%0d_tgt", i), tgt64, 64'd0);
    end
    in_valid64 = 1'b0;
    @(negedge clk);
    chk("x64_in_ready", 64'(in_ready64), 64'd1);

    // Backpressure: A, B accepted, C stalled, then drained in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_code = 32'h00100093;
    @(negedge clk);
    chk("bp_a_head", 64'(imm_out), 64'd1);
    chk("bp_one_ready", 64'(in_ready), 64'd1);
    inst_code = 32'h00200093;
    @(negedge clk);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    chk("bp_a_stable", 64'(imm_out), 64'd1);
    inst_code = 32'h00300093;
    @(negedge clk);
    chk("bp_c_stalled_ready", 64'(in_ready), 64'd0);
    chk("bp_a_still", 64'(imm_out), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_b_head", 64'(imm_out), 64'd2);
    chk("bp_ready_after_pop", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_c_head", 64'(imm_out), 64'd3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with two entries buffered and a concurrent offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    inst_code = 32'h00100093;
    @(negedge clk);
    inst_code = 32'h00200093;
    @(negedge clk);
    chk("fl_full", 64'(in_ready), 64'd0);
    flush     = 1'b1;
    inst_code = 32'h00300093;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("fl_word_lost", 64'(out_valid), 64'd0);

    // Flush with one entry and an accepted-looking push: push discarded
    in_valid  = 1'b1;
    inst_code = 32'h00500093;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-transfer
    in_valid  = 1'b1;
    inst_code = 32'hFFF00093;
    @(negedge clk);
    chk("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_imm", 64'(imm_out), 64'd0);
    chk("ar_fmt", 64'(fmt_out), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_recover_ready", 64'(in_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
